// File: rtl/bme280_i2c_slave_pkg.sv
// Shared definitions for the BME280 I2C target stand-in.
// Holds the FSM state encoding, the R/W bit values and the default
// 7-bit target address (BME280 with SDO tied low).
package bme280_i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,    // wait for START
    ST_ADDR,    // shifting address + R/W
    ST_ACK_A,   // driving address ACK
    ST_PTR,     // shifting register pointer
    ST_ACK_P,   // driving pointer ACK
    ST_WDATA,   // shifting write data
    ST_ACK_W,   // driving write-data ACK
    ST_RDATA,   // driving read data
    ST_RACK,    // SDA released, sampling master ACK/NACK
    ST_IGNORE   // not addressed / done, wait for START or STOP
  } state_e;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam logic [6:0] BME280_ADDR = 7'h76;

endpackage

// File: rtl/bme280_i2c_slave_bus_monitor.sv
// I2C line conditioner: synchronizes SCL/SDA pads and produces single-cycle
// event pulses.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   scl_i, sda_i        raw pad levels
//   sda_o               synchronized SDA level (for bit sampling)
//   scl_rise_o/fall_o   SCL edge pulses
//   start_o, stop_o     START / STOP condition pulses
module bme280_i2c_slave_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Idle bus is high on both lines; reset to that so no false edges appear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high on both sides of the SDA edge to count as START/STOP.
  assign start_o    = sda_prev_q & ~sda_s & scl_s & scl_prev_q;
  assign stop_o     = ~sda_prev_q & sda_s & scl_s & scl_prev_q;

endmodule

// File: rtl/bme280_i2c_slave.sv
// BME280 I2C target: address match, register pointer with auto-increment,
// byte reads/writes through an external register-file port.
// Ports:
//   clk_i, rst_i           system clock (>=10x SCL), sync active-high reset
//   scl_pad_i, sda_pad_i   pad levels (SCL is never driven)
//   sda_pad_o              constant 0 (open drain)
//   sda_pad_en_o           0 pulls SDA low, 1 releases it
//   reg_addr_o             register pointer
//   reg_wr_o, reg_wdata_o  one-cycle write strobe and data
//   reg_rd_o, reg_rdata_i  one-cycle read strobe; rdata captured that cycle
//   busy_o                 addressed transaction in progress
module bme280_i2c_slave
  import bme280_i2c_slave_pkg::*;
#(
  parameter logic [6:0] ADDR        = BME280_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_pad_en_o,
  output logic [7:0] reg_addr_o,
  output logic       reg_wr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  bme280_i2c_slave_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_pad_i),
    .sda_i      (sda_pad_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_en_q, sda_en_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rd_q, rd_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      sda_en_q <= 1'b1;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      rw_q     <= rw_d;
      sda_en_q <= sda_en_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    rw_d     = rw_q;
    sda_en_d = sda_en_q;
    addr_d   = addr_q;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;
    rd_d     = 1'b0;
    busy_d   = busy_q;

    // The read strobe cycle is the one where reg_rdata_i is valid for the
    // (possibly just incremented) pointer; take it into the shifter here.
    if (rd_q) shift_d = reg_rdata_i;

    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_en_d = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_en_d = 1'b1;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: ;
        // ADDR/PTR/WDATA: the SCL fall right after START arrives with
        // cnt_q==0, so only the fall after the 8th bit acts.
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDR && shift_q[7:1] != 7'h00) begin
              state_d  = ST_ACK_A;
              sda_en_d = 1'b0;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ACK_A: begin
          // Fetch the first read byte on the ACK clock so it is ready
          // well before the first data bit is driven.
          if (scl_rise && rw_q == I2C_RD) begin
            rd_d = 1'b1;
          end else if (scl_fall) begin
            cnt_d = '0;
            if (rw_q == I2C_RD) begin
              state_d  = ST_RDATA;
              sda_en_d = shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end else begin
              state_d  = ST_PTR;
              sda_en_d = 1'b1;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            addr_d   = shift_q;
            sda_en_d = 1'b0;
            state_d  = ST_ACK_P;
          end
        end
        ST_ACK_P: begin
          if (scl_fall) begin
            sda_en_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              wr_d    = 1'b1;
              wdata_d = {shift_q[6:0], sda_s};
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_en_d = 1'b0;
            state_d  = ST_ACK_W;
          end
        end
        ST_ACK_W: begin
          if (scl_fall) begin
            sda_en_d = 1'b1;
            cnt_d    = '0;
            addr_d   = addr_q + 8'd1;
            state_d  = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_en_d = 1'b1;
              state_d  = ST_RACK;
            end else begin
              sda_en_d = shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              addr_d = addr_q + 8'd1;
              rd_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            // Still here on the fall means the master ACKed.
            state_d  = ST_RDATA;
            cnt_d    = '0;
            sda_en_d = shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_pad_en_o = sda_en_q;
  assign reg_addr_o   = addr_q;
  assign reg_wr_o     = wr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_rd_o     = rd_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_bme280_i2c_slave.sv
module tb_bme280_i2c_slave;
  import bme280_i2c_slave_pkg::*;

  localparam int Q = 10;  // Clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_pad_o, sda_pad_en, reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & (sda_pad_en ? 1'b1 : sda_pad_o);

  bme280_i2c_slave dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_pad_en_o (sda_pad_en),
    .reg_addr_o   (reg_addr),
    .reg_wr_o     (reg_wr),
    .reg_wdata_o  (reg_wdata),
    .reg_rd_o     (reg_rd),
    .reg_rdata_i  (reg_rdata),
    .busy_o       (busy)
  );

  // register file environment
  logic [7:0]  rf [256];
  logic [7:0]  load_val [256];
  logic        rf_load = 1'b0;
  logic [15:0] wr_log [$];
  int          rd_cnt = 0;

  assign reg_rdata = rf[reg_addr];

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 256; i++) rf[i] <= load_val[i];
    end else if (reg_wr) begin
      rf[reg_addr] <= reg_wdata;
      wr_log.push_back({reg_addr, reg_wdata});
    end
    if (reg_rd) rd_cnt <= rd_cnt + 1;
  end

  // reference model
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;

  int total = 0;
  int bad   = 0;

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic sync_rf();
    for (int i = 0; i < 256; i++) load_val[i] = model_mem[i];
    @(negedge clk) rf_load = 1'b1;
    @(negedge clk) rf_load = 1'b0;
  endtask

  task automatic m_start();
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
  endtask

  task automatic m_bit_w(input logic b);
    sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
  endtask

  task automatic m_bit_r(output logic b);
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = sda_bus; wq(); scl_m = 1'b0; wq();
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) m_bit_w(b[i]);
    m_bit_r(nack);
  endtask

  task automatic m_rbyte(output logic [7:0] b, input logic nack);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      m_bit_r(t);
      b[i] = t;
    end
    m_bit_w(nack);
  endtask

  // START, 0xEC, ptr, n data bytes, STOP; nack_any reports any missing ACK
  task automatic mwrite(input logic [7:0] ptr, input int n, input logic [7:0] d [8],
                        output logic nack_any);
    logic a;
    nack_any = 1'b0;
    m_start();
    m_wbyte(8'hEC, a); nack_any |= a;
    m_wbyte(ptr, a);   nack_any |= a;
    for (int i = 0; i < n; i++) begin
      m_wbyte(d[i], a); nack_any |= a;
    end
    m_stop();
  endtask

  // optional pointer set + repeated START, then read n bytes (last NACKed)
  task automatic mread(input logic set_ptr, input logic [7:0] ptr, input int n,
                       output logic [7:0] got [8], output logic nack_any,
                       output logic busy_end);
    logic a;
    nack_any = 1'b0;
    m_start();
    if (set_ptr) begin
      m_wbyte(8'hEC, a); nack_any |= a;
      m_wbyte(ptr, a);   nack_any |= a;
      m_start();
    end
    m_wbyte(8'hED, a); nack_any |= a;
    for (int i = 0; i < n; i++) m_rbyte(got[i], (i == n - 1));
    busy_end = busy;
    m_stop();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom);
    model_ptr = 8'h00;
    rst = 1'b1;
    sync_rf();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (sda_pad_en !== 1'b1) begin bad++; $display("FAIL reset_sda_en got=%b exp=1", sda_pad_en); end
    total++; if (sda_pad_o !== 1'b0) begin bad++; $display("FAIL reset_sda_o got=%b exp=0", sda_pad_o); end
    total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
    total++; if (reg_wr !== 1'b0 || reg_rd !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", reg_wr, reg_rd); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write();
    logic [7:0] d [8];
    logic na;
    int base;
    base = wr_log.size();
    d[0] = 8'h27;
    mwrite(8'hF4, 1, d, na);
    model_mem[8'hF4] = 8'h27;
    model_ptr = 8'hF4 + 8'd1;
    total++; if (na !== 1'b0) begin bad++; $display("FAIL write_acks got=%b exp=0", na); end
    total++;
    if (wr_log.size() - base !== 1) begin
      bad++; $display("FAIL write_count got=%0d exp=1", wr_log.size() - base);
    end else if (wr_log[base] !== 16'hF427) begin
      bad++; $display("FAIL write_entry got=%h exp=f427", wr_log[base]);
    end
    total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL write_ptr got=%h exp=%h", reg_addr, model_ptr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy got=%b exp=0", busy); end
  endtask

  task automatic test_burst_read();
    logic [7:0] got [8];
    logic na, be;
    int rd0;
    model_mem[8'h88] = 8'h70; model_mem[8'h89] = 8'h6B; model_mem[8'h8A] = 8'h43;
    sync_rf();
    rd0 = rd_cnt;
    mread(1'b1, 8'h88, 3, got, na, be);
    model_ptr = 8'h88 + 8'd2;
    total++; if (na !== 1'b0) begin bad++; $display("FAIL burst_acks got=%b exp=0", na); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== model_mem[8'h88 + 8'(i)]) begin
        bad++; $display("FAIL burst_byte%0d got=%h exp=%h", i, got[i], model_mem[8'h88 + 8'(i)]);
      end
    end
    total++; if (rd_cnt - rd0 !== 3) begin bad++; $display("FAIL burst_rd_count got=%0d exp=3", rd_cnt - rd0); end
    total++; if (be !== 1'b0) begin bad++; $display("FAIL burst_busy_nack got=%b exp=0", be); end
    total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL burst_ptr got=%h exp=%h", reg_addr, model_ptr); end
  endtask

  task automatic test_mismatch();
    logic a1, a2, a3, b1;
    int base, rd0;
    base = wr_log.size();
    rd0 = rd_cnt;
    m_start();
    m_wbyte(8'hEE, a1);
    b1 = busy;
    m_wbyte(8'h55, a2);
    m_stop();
    m_start();
    m_wbyte(8'h00, a3);
    m_stop();
    total++; if (a1 !== 1'b1 || a2 !== 1'b1) begin bad++; $display("FAIL mismatch_nack got=%b%b exp=11", a1, a2); end
    total++; if (b1 !== 1'b0) begin bad++; $display("FAIL mismatch_busy got=%b exp=0", b1); end
    total++; if (wr_log.size() !== base || rd_cnt !== rd0) begin
      bad++; $display("FAIL mismatch_strobes got wr=%0d rd=%0d exp 0 0", wr_log.size() - base, rd_cnt - rd0);
    end
    total++; if (a3 !== 1'b1) begin bad++; $display("FAIL general_call_nack got=%b exp=1", a3); end
  endtask

  task automatic test_wrap();
    logic [7:0] d [8];
    logic na;
    int base;
    logic [15:0] exp;
    base = wr_log.size();
    d[0] = 8'hAA; d[1] = 8'h55;
    mwrite(8'hFF, 2, d, na);
    total++; if (na !== 1'b0) begin bad++; $display("FAIL wrap_acks got=%b exp=0", na); end
    total++;
    if (wr_log.size() - base !== 2) begin
      bad++; $display("FAIL wrap_count got=%0d exp=2", wr_log.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp = {8'hFF + 8'(i), d[i]};
        total++;
        if (wr_log[base + i] !== exp) begin bad++; $display("FAIL wrap_entry%0d got=%h exp=%h", i, wr_log[base + i], exp); end
        model_mem[exp[15:8]] = d[i];
      end
    end
    model_ptr = 8'hFF + 8'd2;
    total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL wrap_ptr got=%h exp=%h", reg_addr, model_ptr); end
  endtask

  task automatic test_abort();
    logic a1, a2;
    int base;
    base = wr_log.size();
    m_start();
    m_wbyte(8'hEC, a1);
    m_wbyte(8'h30, a2);
    for (int i = 0; i < 4; i++) m_bit_w(1'($urandom));
    m_stop();
    @(negedge clk);
    model_ptr = 8'h30;
    total++; if (a1 !== 1'b0 || a2 !== 1'b0) begin bad++; $display("FAIL abort_acks got=%b%b exp=00", a1, a2); end
    total++; if (wr_log.size() !== base) begin bad++; $display("FAIL abort_no_write got=%0d exp=0", wr_log.size() - base); end
    total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL abort_ptr got=%h exp=%h", reg_addr, model_ptr); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_random();
    logic [7:0] d [8];
    logic [7:0] got [8];
    logic [7:0] ptr, start, ea;
    logic [15:0] exp;
    logic na, be, setp;
    int n, base, rd0;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 4);
      ptr = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) d[i] = 8'($urandom);
        base = wr_log.size();
        mwrite(ptr, n, d, na);
        total++; if (na !== 1'b0) begin bad++; $display("FAIL rnd%0d_wr_acks got=%b exp=0", it, na); end
        total++;
        if (wr_log.size() - base !== n) begin
          bad++; $display("FAIL rnd%0d_wr_count got=%0d exp=%0d", it, wr_log.size() - base, n);
        end else begin
          for (int i = 0; i < n; i++) begin
            ea = ptr + 8'(i);
            exp = {ea, d[i]};
            total++;
            if (wr_log[base + i] !== exp) begin bad++; $display("FAIL rnd%0d_wr_entry%0d got=%h exp=%h", it, i, wr_log[base + i], exp); end
          end
        end
        for (int i = 0; i < n; i++) model_mem[ptr + 8'(i)] = d[i];
        model_ptr = ptr + 8'(n);
      end else begin
        setp = 1'($urandom);
        start = setp ? ptr : model_ptr;
        rd0 = rd_cnt;
        mread(setp, ptr, n, got, na, be);
        total++; if (na !== 1'b0) begin bad++; $display("FAIL rnd%0d_rd_acks got=%b exp=0", it, na); end
        for (int i = 0; i < n; i++) begin
          ea = start + 8'(i);
          total++;
          if (got[i] !== model_mem[ea]) begin bad++; $display("FAIL rnd%0d_rd_byte%0d got=%h exp=%h", it, i, got[i], model_mem[ea]); end
        end
        total++; if (rd_cnt - rd0 !== n) begin bad++; $display("FAIL rnd%0d_rd_count got=%0d exp=%0d", it, rd_cnt - rd0, n); end
        total++; if (be !== 1'b0) begin bad++; $display("FAIL rnd%0d_rd_busy got=%b exp=0", it, be); end
        model_ptr = start + 8'(n - 1);
      end
      total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL rnd%0d_ptr got=%h exp=%h", it, reg_addr, model_ptr); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d [8];
    logic a, na;
    int base;
    model_mem[8'h40] = 8'h3C;  // MSB 0: target pulls SDA for the first bit
    sync_rf();
    m_start();
    m_wbyte(8'hEC, a);
    m_wbyte(8'h40, a);
    m_start();
    m_wbyte(8'hED, a);
    total++; if (sda_pad_en !== 1'b0) begin bad++; $display("FAIL rmr_driving got=%b exp=0", sda_pad_en); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_ptr = 8'h00;
    total++; if (sda_pad_en !== 1'b1) begin bad++; $display("FAIL rmr_release got=%b exp=1", sda_pad_en); end
    total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL rmr_ptr got=%h exp=%h", reg_addr, model_ptr); end
    base = wr_log.size();
    d[0] = 8'h5A;
    mwrite(8'h12, 1, d, na);
    model_mem[8'h12] = 8'h5A;
    model_ptr = 8'h13;
    total++; if (na !== 1'b0) begin bad++; $display("FAIL rmr_write_acks got=%b exp=0", na); end
    total++;
    if (wr_log.size() - base !== 1) begin
      bad++; $display("FAIL rmr_write_count got=%0d exp=1", wr_log.size() - base);
    end else if (wr_log[base] !== 16'h125A) begin
      bad++; $display("FAIL rmr_write_entry got=%h exp=125a", wr_log[base]);
    end
    total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL rmr_final_ptr got=%h exp=%h", reg_addr, model_ptr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_read();
    test_mismatch();
    test_wrap();
    test_abort();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bme280_i2c_slave.md
# bme280_i2c_slave

Synthesizable I2C target (responder) that answers the BME280 transaction set issued by the meteo station's I2C master. Used as an on-FPGA sensor stand-in for board bring-up and as the bus-functional responder in system benches. Decodes START/STOP, matches a 7-bit address, and handles a register pointer with auto-increment. Byte reads and writes go through an external register-file port.

## Interface
- `ADDR`, default 7'h76: target 7-bit address (BME280 with SDO tied low).
- `SYNC_STAGES`, default 2: synchronizer depth on `SclPadIn` and `SdaPadIn`, ≥2.
- `Clk`  in  1  system clock, must be ≥10× SCL frequency.
- `Rst`  in  1  reset: one clock, synchronous, active-high.
- `SclPadIn`  in  1  SCL pad level. SCL is never driven; there is no clock stretching.
- `SdaPadIn`  in  1  SDA pad level.
- `SdaPadOut`  out  1  constant 0 (open-drain).
- `SdaPadEn`  out  1  0 pulls SDA low, 1 releases it (high-Z).
- `RegAddr`  out  8  register pointer.
- `RegWr`  out  1  one-cycle write strobe.
- `RegWdata`  out  8  write data, valid while `RegWr` is high.
- `RegRd`  out  1  one-cycle strobe when `RegRdata` is captured.
- `RegRdata`  in  8  combinational read data at `RegAddr`.
- `Busy`  out  1  high from an address match until STOP, address NACK, or end of a read.

## Operation
- **Line conditioning**
  - SCL and SDA pass through `SYNC_STAGES` flops, then edge detection.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit timing**
  - Bits are sampled on the SCL rising edge.
  - SDA is changed only on an SCL falling edge.
- **States**
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On a match, go to ACK_A and drive SDA low. On a mismatch, go to IGNORE with SDA released.
  - ACK_A: if R/W=0, go to PTR. If R/W=1, capture `RegRdata` (`RegRd` pulse) and go to RDATA.
  - PTR: shift 8 bits, load `RegAddr`, then ACK and go to WDATA.
  - WDATA: shift 8 bits. On the 8th rising edge, pulse `RegWr` with the shifted byte. Then ACK; `RegAddr` increments on the ACK falling edge.
  - RDATA: drive MSB first. Release SDA for the 9th bit and sample the master's ACK.
    - ACK (SDA=0): increment `RegAddr`, pulse `RegRd`, load the next byte, stay in RDATA.
    - NACK: go to IGNORE with SDA released and `Busy` low.
  - IGNORE: SDA released. Wait for START or STOP.
- **Any-state rules**
  - START in any state, including a repeated START, goes to ADDR with SDA released.
  - STOP in any state goes to IDLE with SDA released.
  - A partial byte is discarded: no `RegWr`, pointer unchanged.
- **Pointer rules**
  - The pointer wraps 8'hFF→8'h00.
  - The pointer persists across transactions. A read without a preceding pointer write starts at the last pointer value.
- **General call** (address 0) is NACKed.

## Timing
- **Reset values:** `SdaPadEn`=1, `SdaPadOut`=0, `RegAddr`=8'h00, `RegWr`=0, `RegRd`=0, `RegWdata`=8'h00, `Busy`=0, state IDLE, shift register cleared.
- **Detection latency:** an SCL/SDA pad edge is detected `SYNC_STAGES`+1 Clk after it occurs.
- **SDA drive:** `SdaPadEn` changes on the Clk after a detected SCL falling edge.
- **ACK drive:** SDA is held low from the falling edge after bit 8 until the falling edge after bit 9.
- **Strobes:**
  - `RegRd` precedes the first data-bit drive by ≥1 Clk.
  - `RegRdata` is sampled in the same cycle as `RegRd`.
- **Simultaneous events:**
  - STOP/START detection takes priority over bit sampling in the same cycle.
  - `Rst` takes priority over everything: SDA is released on the next Clk even mid-ACK or mid-read-bit.

## Structure
- Shared include `i2c_defs.vh`: state encodings, `I2C_RD`/`I2C_WR` bit constants, default BME280 address 7'h76.
- Sub-module `i2c_bus_monitor`: synchronizers plus `SclRise`, `SclFall`, `StartDet`, `StopDet` single-cycle pulses.
- Top FSM, bit counter (0–8), shift register and pointer live in `bme280_i2c_slave`.

## Test plan
- **Register write:** START, 0xEC, 0xF4, 0x27, STOP.
  - Three ACKs (SDA low on the 9th bit).
  - One `RegWr` with `RegAddr`=0xF4, `RegWdata`=0x27.
  - `RegAddr`=0xF5 afterwards.
- **Burst read:** START, 0xEC, 0x88, repeated START, 0xED, 3 bytes read with ACK, ACK, NACK, then STOP. Register file holds 0x88=0x70, 0x89=0x6B, 0x8A=0x43.
  - Master receives 0x70, 0x6B, 0x43.
  - Three `RegRd` pulses.
  - `Busy`=0 after the NACK; final `RegAddr`=0x8A.
- **Address mismatch:** START, 0xEE, 0x55, STOP.
  - SDA high on every 9th bit.
  - No `RegWr` or `RegRd`; `Busy` stays 0.
- **Pointer wrap:** write pointer 0xFF, then data 0xAA, 0x55.
  - `RegWr` at `RegAddr`=0xFF then at 0x00.
- **Abort mid-byte:** STOP after 4 data bits of a WDATA byte.
  - No `RegWr`; pointer unchanged; state IDLE.
- **Reset mid-read:** assert `Rst` for 1 Clk while the target drives a 0 bit.
  - `SdaPadEn`=1 on the next Clk; `RegAddr`=0x00; a following full write transaction is ACKed normally.
